// File: rtl/spm_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module   : spm_mult_seq
//  Purpose  : Sequencer for the serial-parallel multiplier CSA chain.
//             - Accepts a parallel multiplier word over valid/ready.
//             - Pulses a one-cycle clear to the chain.
//             - Streams the multiplier LSB-first into the chain's y input.
//             - Deserialises the chain's serial product into a 2*WIDTH word,
//               then offers it over valid/ready.
//  Options  : define SPM_MULT_SEQ_SIGNED_EN for a two's-complement multiplier.
//             Without it, the upper WIDTH serial bits are zero (unsigned).
//  Revision : 1.0  initial release
// ============================================================================
module spm_mult_seq #(
  parameter int WIDTH     = 32,
  parameter int CHAIN_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,        // asynchronous, active-low
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_y,
  output logic                 y_ser,
  output logic                 chain_clr,
  input  logic                 p_ser,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 busy
);

  // Counter sized so the post-increment value after the final shift count
  // still fits; the counter therefore never wraps inside an operation.
  localparam int c_PW        = 2 * WIDTH;
  localparam int c_CNT_W     = $clog2(2 * WIDTH + CHAIN_LAT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(2 * WIDTH + CHAIN_LAT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_WIDTH = c_CNT_W'(WIDTH);
  localparam logic [c_CNT_W-1:0] c_CNT_LAT   = c_CNT_W'(CHAIN_LAT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_y;
  logic [c_PW-1:0]      r_p;
  logic [c_CNT_W-1:0]   r_cnt;

  logic                 w_load;
  logic                 w_shift_en;
  logic                 w_capture;
  logic                 w_ext;
  logic                 w_ybit;
  logic [WIDTH-1:0]     w_y_shifted;

  // State register; reset returns to IDLE from any state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and state-decoded control outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    chain_clr   = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    w_load      = 1'b0;
    w_shift_en  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        chain_clr   = 1'b1;
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_shift_en = 1'b1;
        if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Bit fed to the chain once the multiplier word is exhausted.
`ifdef SPM_MULT_SEQ_SIGNED_EN
  assign w_ext = r_y[WIDTH-1];
`else
  assign w_ext = 1'b0;
`endif

  // Product bits only become meaningful CHAIN_LAT counts after the first
  // y bit; with zero latency every shift count captures.
  generate
    if (CHAIN_LAT == 0) begin : g_lat_zero
      assign w_capture = 1'b1;
    end else begin : g_lat_nonzero
      assign w_capture = (r_cnt >= c_CNT_LAT);
    end
  endgenerate

  // Select multiplier bit cnt; beyond the word, drive the extension bit.
  assign w_y_shifted = r_y >> r_cnt;
  assign w_ybit      = (r_cnt < c_CNT_WIDTH) ? w_y_shifted[0] : w_ext;
  assign y_ser       = w_shift_en & w_ybit;

  assign out_p = r_p;

  // Operand latch, shift counter and product deserialiser.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_y   <= '0;
      r_p   <= '0;
      r_cnt <= '0;
    end else begin
      if (w_load) begin
        r_y <= in_y;
      end
      if (chain_clr) begin
        r_cnt <= '0;
      end else if (w_shift_en) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Right shift: after 2*WIDTH captures the first product bit sits in
      // bit 0 and the last one in the MSB.
      if (w_shift_en && w_capture) begin
        r_p <= {p_ser, r_p[c_PW-1:1]};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spm_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spm_mult_seq
//  Purpose  : Self-checking bench for spm_mult_seq (WIDTH=4, CHAIN_LAT=1)
//             with a behavioural CSA chain model (x=3, one-cycle latency).
//  Revision : 1.0  initial release
// ============================================================================
module tb_spm_mult_seq;

  localparam int W = 4;
  localparam int L = 1;
  localparam logic [15:0] c_X = 16'd3;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       in_valid  = 1'b0;
  logic [3:0] in_y      = 4'h0;
  logic       p_ser     = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_ready;
  logic       y_ser;
  logic       chain_clr;
  logic       out_valid;
  logic [7:0] out_p;
  logic       busy;

  int checks = 0;
  int errors = 0;

  spm_mult_seq #(.WIDTH(W), .CHAIN_LAT(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_y      (in_y),
    .y_ser     (y_ser),
    .chain_clr (chain_clr),
    .p_ser     (p_ser),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Chain model: accumulates the serial multiplier bits received since the
  // last clear and returns bit k of x*Y one cycle after y bit k arrives.
  logic [15:0] acc  = '0;
  logic [15:0] prod = '0;
  int          k    = 0;
  always @(posedge clk) begin
    if (chain_clr) begin
      acc = '0;
      k   = 0;
      p_ser <= 1'b0;
    end else if (k < 16) begin
      acc[k] = y_ser;
      prod   = acc * c_X;
      p_ser <= prod[k];
      k++;
    end else begin
      p_ser <= 1'b0;
    end
  end

  function automatic logic ext_bit(input logic [3:0] y);
`ifdef SPM_MULT_SEQ_SIGNED_EN
    return y[3];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] ref_prod(input logic [3:0] y);
    int v;
    v = int'(y);
`ifdef SPM_MULT_SEQ_SIGNED_EN
    if (y[3]) v = v - 16;
`endif
    v = v * 3;
    return v[7:0];
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic reset_values(input string tag);
    check({tag, "_in_ready"},  8'(in_ready),  8'd1);
    check({tag, "_busy"},      8'(busy),      8'd0);
    check({tag, "_out_valid"}, 8'(out_valid), 8'd0);
    check({tag, "_out_p"},     out_p,         8'h00);
    check({tag, "_chain_clr"}, 8'(chain_clr), 8'd0);
    check({tag, "_y_ser"},     8'(y_ser),     8'd0);
  endtask

  // One operation: handshake, clear, shift, done with bp cycles of
  // backpressure. junk keeps in_valid high with 4'hF while busy.
  // abort_at >= 0 asserts reset at that shift count and returns.
  task automatic run_op(input logic [3:0] y, input int bp, input bit junk, input int abort_at);
    logic [7:0] exp_p;
    logic       ext;
    logic       expb;
    exp_p = ref_prod(y);
    ext   = ext_bit(y);
    @(negedge clk);
    check("idle_in_ready", 8'(in_ready), 8'd1);
    check("idle_busy", 8'(busy), 8'd0);
    in_valid  = 1'b1;
    in_y      = y;
    out_ready = (bp == 0);
    @(negedge clk);
    check("clear_pulse", 8'(chain_clr), 8'd1);
    check("clear_in_ready", 8'(in_ready), 8'd0);
    check("clear_busy", 8'(busy), 8'd1);
    check("clear_y_ser", 8'(y_ser), 8'd0);
    if (junk) in_y = 4'hF;
    else      in_valid = 1'b0;
    for (int c = 0; c < 2*W + L; c++) begin
      @(negedge clk);
      if (c == abort_at) begin
        rst = 1'b0;
        #1;
        reset_values("abort_async");
        @(negedge clk);
        reset_values("abort_held");
        in_valid = 1'b0;
        rst      = 1'b1;
        return;
      end
      if (c < W) expb = y[c];
      else       expb = ext;
      check("shift_y_ser", 8'(y_ser), 8'(expb));
      check("shift_chain_clr", 8'(chain_clr), 8'd0);
      check("shift_out_valid", 8'(out_valid), 8'd0);
      check("shift_in_ready", 8'(in_ready), 8'd0);
    end
    @(negedge clk);
    for (int i = 0; i < bp; i++) begin
      check("bp_out_valid", 8'(out_valid), 8'd1);
      check("bp_out_p", out_p, exp_p);
      check("bp_in_ready", 8'(in_ready), 8'd0);
      check("bp_y_ser", 8'(y_ser), 8'd0);
      @(negedge clk);
    end
    check("done_out_valid", 8'(out_valid), 8'd1);
    check("done_out_p", out_p, exp_p);
    check("done_in_ready", 8'(in_ready), 8'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_in_ready", 8'(in_ready), 8'd1);
    check("post_out_valid", 8'(out_valid), 8'd0);
    check("post_busy", 8'(busy), 8'd0);
  endtask

  initial begin
    #1;
    reset_values("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    run_op(4'b0101, 0, 1'b0, -1);   // 3*5 = 8'h0F
    run_op(4'b1011, 0, 1'b0, -1);   // 3*11 = 8'h21, or 3*(-5) = 8'hF1 signed
    run_op(4'b0110, 5, 1'b0, -1);   // backpressure, handshake on 6th cycle
    run_op(4'b0011, 2, 1'b1, -1);   // in_valid held high while busy
    run_op(4'b0111, 0, 1'b0, 3);    // reset at cnt=3
    run_op(4'd2,    0, 1'b0, -1);   // 8'h06 after reset
    run_op(4'h0,    0, 1'b0, -1);
    run_op(4'hF,    1, 1'b0, -1);
    run_op(4'h8,    0, 1'b0, -1);

    for (int n = 0; n < 30; n++) begin
      run_op(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spm_mult_seq.md
# spm_mult_seq

Sequencer wrapped around the serial-parallel multiplier CSA chain. Accepts a parallel multiplier word over a valid/ready handshake and clears the chain. It then drives the multiplier LSB-first into the chain's serial `y` input and deserialises the chain's serial product bit into a 2*WIDTH-bit word. The result is presented on a valid/ready output. The block sits directly upstream (`y_ser`) and downstream (`p_ser`) of the `genblk1[*].csa` cells.

## Interface
- `WIDTH`, 32: operand width; product width is 2*WIDTH.
- `CHAIN_LAT`, 1: cycles from a `y_ser` bit to its product bit on `p_ser`; must be ≥ 0.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  multiplier word offered.
- `in_ready`  out  1  block can accept a word.
- `in_y`  in  WIDTH  multiplier word.
- `y_ser`  out  1  serial multiplier bit to the CSA chain `y` input.
- `chain_clr`  out  1  synchronous clear pulse to the CSA chain state.
- `p_ser`  in  1  serial product bit from the chain.
- `out_valid`  out  1  product available.
- `out_ready`  in  1  consumer takes product.
- `out_p`  out  2*WIDTH  product word.
- `busy`  out  1  high in any state except IDLE.

## Operation
- **States:** IDLE, CLEAR, SHIFT, DONE.
- **IDLE**
  - `in_ready`=1.
  - Handshake (`in_valid`&`in_ready`) latches `in_y` into `y_reg` and goes to CLEAR.
- **CLEAR**
  - `chain_clr`=1 for exactly one cycle.
  - Counter `cnt` set to 0; next state SHIFT.
- **SHIFT**
  - Runs for `cnt` = 0 … 2*WIDTH+CHAIN_LAT-1.
  - `y_ser` = `y_reg[cnt]` for `cnt` < WIDTH.
  - For `cnt` ≥ WIDTH, `y_ser` = extension bit (see Configuration).
  - For `cnt` ≥ CHAIN_LAT, `p_ser` is shifted into `p_reg` MSB (right shift).
  - After 2*WIDTH captures, `p_reg[0]` holds the first product bit.
  - Last count goes to DONE.
- **DONE**
  - `out_valid`=1; `out_p` = `p_reg`, held stable.
  - `out_valid`&`out_ready` goes to IDLE.
- **Counter:** `cnt` width is clog2(2*WIDTH+CHAIN_LAT+1); it never wraps within an operation.
- **Outputs outside SHIFT:** `y_ser`=0.
- **`in_valid` while busy:** ignored, no state change.
- **`out_ready` outside DONE:** ignored.
- **Reset (any time, including mid-SHIFT or mid-DONE):**
  - State goes to IDLE.
  - `y_reg`, `p_reg`, `cnt` go to 0.
  - All outputs go low except `in_ready`=1.
- **Reset values:** `in_ready`=1; `y_ser`=0, `chain_clr`=0, `out_valid`=0, `out_p`=0, `busy`=0.

## Timing
- **Handshake edge T.** The following cycle numbers are relative to T:
  - CLEAR at T+1 (`chain_clr` high).
  - First `y_ser` bit at T+2.
  - `out_valid` rises at T+2+2*WIDTH+CHAIN_LAT.
- **Throughput:** one operation per 3+2*WIDTH+CHAIN_LAT cycles minimum, with `out_ready` held high.
- **Back-to-back:** no overlap; `in_ready` returns the cycle after the output handshake.
- **Output stability:** `out_p` changes only in SHIFT or on reset; it is stable across all DONE cycles.
- **CHAIN_LAT=0:** `p_ser` is captured in the same cycle as the `y_ser` bit.

## Configuration
- Macro `SPM_MULT_SEQ_SIGNED_EN`.
- **Defined:** extension bit = `y_reg[WIDTH-1]` (two's-complement sign extension); the product is a signed 2*WIDTH result.
- **Undefined:** extension bit = 0 (unsigned multiply).
- Nothing else differs; the port list is identical in both builds.

## Test plan
All scenarios use WIDTH=4, CHAIN_LAT=1, and a behavioural chain model with x=3 that returns product bits delayed one cycle.

- **Unsigned multiply (macro undefined).**
  - Stimulus: `in_y`=4'b0101, accepted at T.
  - `chain_clr` high at T+1 only.
  - `y_ser` over T+2..T+9 = 1,0,1,0,0,0,0,0.
  - `out_valid` at T+11; `out_p`=8'h0F.
- **Signed multiply (macro defined).**
  - Stimulus: `in_y`=4'b1011 (-5).
  - `y_ser` over T+2..T+9 = 1,1,0,1,1,1,1,1.
  - `out_p`=8'hF1 (-15).
- **Output backpressure.**
  - Stimulus: `out_ready` low for 5 cycles after `out_valid` rises.
  - `out_valid` stays 1 and `out_p` stays constant.
  - `in_ready`=0 throughout.
  - Handshake on cycle 6; `in_ready`=1 the next cycle.
- **Input while busy.**
  - Stimulus: `in_valid` held high with `in_y`=4'hF during SHIFT.
  - No capture occurs; the product of the original operand is unchanged.
  - The next operation starts only after DONE→IDLE.
- **Reset mid-SHIFT.**
  - Stimulus: `rst` low at `cnt`=3.
  - Asynchronously: `busy`=0, `out_valid`=0, `out_p`=0, `in_ready`=1.
  - A new operation with `in_y`=2 afterwards gives `out_p`=8'h06.
